// File: rtl/hipass_gate_ctrl.sv
// rtl/hipass_gate_ctrl.sv - toll gate controller fed by vehicle count changes
// Buffers tagged vehicle events in a small FIFO and serves them one at a time.
module hipass_gate_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int OPEN_CYCLES  = 4,
  parameter int ALARM_CYCLES = 3,
  parameter int TOLL_UNIT    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  count,
  input  logic [3:0]  hipass_in,
  output logic        gate_open,
  output logic        alarm,
  output logic        busy,
  output logic        fifo_full,
  output logic [7:0]  pass_cnt,
  output logic [7:0]  viol_cnt,
  output logic [7:0]  drop_cnt,
  output logic [15:0] toll_total
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = 16;

  typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_OPEN, S_ALARM} state_t;

  state_t        state;
  logic [3:0]    count_q;
  logic [3:0]    tag_q;
  logic [3:0]    head_tag;
  logic [TW-1:0] timer;
  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          vehicle_event;
  logic          fifo_empty;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [15:0]   charge;
  logic [16:0]   toll_sum;

  assign vehicle_event = (count != count_q);
  assign fifo_empty    = (occ == '0);
  assign fifo_full     = (occ == (AW+1)'(FIFO_DEPTH));
  assign pop           = (state == S_IDLE) && !fifo_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok       = vehicle_event && (!fifo_full || pop);
  assign drop          = vehicle_event && fifo_full && !pop;
  assign head_tag      = fifo_mem[rd_ptr];
  assign busy          = (state != S_IDLE) || !fifo_empty;
  assign charge        = 16'(tag_q) * 16'(TOLL_UNIT);
  assign toll_sum      = {1'b0, toll_total} + {1'b0, charge};

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= hipass_in;
  end

  always_ff @(posedge clk) begin
    count_q <= count;
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      occ <= occ + 1'b1;
      else if (pop && !push_ok) occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tag_q      <= '0;
      timer      <= '0;
      gate_open  <= 1'b0;
      alarm      <= 1'b0;
      pass_cnt   <= '0;
      viol_cnt   <= '0;
      drop_cnt   <= '0;
      toll_total <= '0;
    end else begin
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      case (state)
        S_IDLE: begin
          if (pop) begin
            tag_q <= head_tag;
            if (head_tag != 4'd0) begin
              state <= S_CHARGE;
            end else begin
              state <= S_ALARM;
              alarm <= 1'b1;
              timer <= TW'(ALARM_CYCLES - 1);
              if (viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
            end
          end
        end
        S_CHARGE: begin
          toll_total <= toll_sum[16] ? 16'hFFFF : toll_sum[15:0];
          if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
          timer     <= TW'(OPEN_CYCLES - 1);
          gate_open <= 1'b1;
          state     <= S_OPEN;
        end
        S_OPEN: begin
          if (timer == '0) begin
            gate_open <= 1'b0;
            state     <= S_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_ALARM: begin
          if (timer == '0) begin
            alarm <= 1'b0;
            state <= S_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
